// File: rtl/seq_detector_param_if.sv
// Serial-bit, control and status bundle for seq_detector_param.
// The master drives the stream and controls; the slave (detector) reports status.
interface seq_detector_param_if #(
  parameter int PAT_W = 6,
  parameter int CNT_W = 8
);
  localparam int FILL_W = $clog2(PAT_W + 1);

  logic              in_valid;
  logic              in_bit;
  logic              overlap;
  logic              load;
  logic [PAT_W-1:0]  load_pat;
  logic              cnt_clr;
  logic              flag;
  logic [CNT_W-1:0]  match_cnt;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  pat;

  modport master (
    output in_valid, in_bit, overlap, load, load_pat, cnt_clr,
    input  flag, match_cnt, fill, pat
  );

  modport slave (
    input  in_valid, in_bit, overlap, load, load_pat, cnt_clr,
    output flag, match_cnt, fill, pat
  );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with run-time pattern reload,
// selectable overlap, saturating match counter and fill progress output.
module seq_detector_param #(
  parameter int               PAT_W   = 6,
  parameter logic [PAT_W-1:0] PATTERN = 6'b101011,
  parameter int               CNT_W   = 8
) (
  input logic                 clk,
  input logic                 reset,
  seq_detector_param_if.slave bus
);
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_W-1:0]  pat_reg;
  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill_reg;
  logic              flag_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [PAT_W-1:0]  hist_n;
  logic [FILL_W-1:0] fill_n;
  logic              match;

  // A match only counts when a qualified bit is accepted, never on a load edge.
  always_comb begin
    hist_n = {hist[PAT_W-2:0], bus.in_bit};
    fill_n = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + FILL_W'(1);
    match  = bus.in_valid && !bus.load &&
             (fill_n == FILL_FULL) && (hist_n == pat_reg);
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      pat_reg  <= PATTERN;
      hist     <= '0;
      fill_reg <= '0;
      flag_reg <= 1'b0;
    end else if (bus.load) begin
      pat_reg  <= bus.load_pat;
      hist     <= '0;
      fill_reg <= '0;
      flag_reg <= 1'b0;
    end else if (bus.in_valid) begin
      flag_reg <= match;
      if (match && !bus.overlap) begin
        hist     <= '0;
        fill_reg <= '0;
      end else begin
        hist     <= hist_n;
        fill_reg <= fill_n;
      end
    end else begin
      flag_reg <= 1'b0;
    end
  end

  // Counter clear beats a simultaneous match; increments stop at all-ones.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (bus.cnt_clr) begin
      cnt_reg <= '0;
    end else if (match && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign bus.flag      = flag_reg;
  assign bus.match_cnt = cnt_reg;
  assign bus.fill      = fill_reg;
  assign bus.pat       = pat_reg;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed, table-driven bench for seq_detector_param plus hand-written
// sequences for asynchronous reset mid-stream and counter saturation.
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_detector_param_if #(.PAT_W(6), .CNT_W(8)) bus  ();
  seq_detector_param_if #(.PAT_W(6), .CNT_W(2)) bus2 ();

  seq_detector_param #(.PAT_W(6), .PATTERN(6'b101011), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  seq_detector_param #(.PAT_W(6), .PATTERN(6'b101011), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  typedef struct {
    logic       load;
    logic [5:0] load_pat;
    logic       valid;
    logic       din;
    logic       overlap;
    logic       cnt_clr;
    logic       exp_flag;
    int         exp_cnt;
    int         exp_fill;
    logic [5:0] exp_pat;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic ld, input logic [5:0] lp, input logic v,
                        input logic d, input logic ov, input logic clr,
                        input logic ef, input int ec, input int efl,
                        input logic [5:0] ep);
    vec_t t;
    t.load = ld; t.load_pat = lp; t.valid = v; t.din = d; t.overlap = ov;
    t.cnt_clr = clr; t.exp_flag = ef; t.exp_cnt = ec; t.exp_fill = efl;
    t.exp_pat = ep;
    vecs.push_back(t);
  endtask

  // Plain valid bit with no load/clear.
  task automatic addBit(input logic d, input logic ov, input logic ef,
                        input int ec, input int efl, input logic [5:0] ep);
    addVec(1'b0, 6'b0, 1'b1, d, ov, 1'b0, ef, ec, efl, ep);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive away from the falling (active) edge, sample just after it.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    bus.load     = v.load;
    bus.load_pat = v.load_pat;
    bus.in_valid = v.valid;
    bus.in_bit   = v.din;
    bus.overlap  = v.overlap;
    bus.cnt_clr  = v.cnt_clr;
    @(negedge clk);
    #1;
  endtask

  task automatic checkVec(input int idx, input vec_t v);
    checkOutput($sformatf("v%0d flag", idx), int'(bus.flag), int'(v.exp_flag));
    checkOutput($sformatf("v%0d cnt", idx), int'(bus.match_cnt), v.exp_cnt);
    checkOutput($sformatf("v%0d fill", idx), int'(bus.fill), v.exp_fill);
    checkOutput($sformatf("v%0d pat", idx), int'(bus.pat), int'(v.exp_pat));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    localparam logic [5:0] P0 = 6'b101011;
    localparam logic [5:0] P1 = 6'b101010;
    localparam logic [5:0] P2 = 6'b110011;
    vec_t v;
    int   flags2;
    int   exp_cnt2;

    bus.load = 0; bus.load_pat = '0; bus.in_valid = 0; bus.in_bit = 0;
    bus.overlap = 0; bus.cnt_clr = 0;
    bus2.load = 0; bus2.load_pat = '0; bus2.in_valid = 0; bus2.in_bit = 0;
    bus2.overlap = 0; bus2.cnt_clr = 0;

    // Default pattern, overlap off
    addBit(1, 0, 0, 0, 1, P0); addBit(0, 0, 0, 0, 2, P0);
    addBit(1, 0, 0, 0, 3, P0); addBit(0, 0, 0, 0, 4, P0);
    addBit(1, 0, 0, 0, 5, P0); addBit(1, 0, 1, 1, 0, P0);
    addVec(0, 6'b0, 0, 0, 0, 0, 0, 1, 0, P0);
    // Default pattern, overlap on: fill stays saturated after the match
    addBit(1, 1, 0, 1, 1, P0); addBit(0, 1, 0, 1, 2, P0);
    addBit(1, 1, 0, 1, 3, P0); addBit(0, 1, 0, 1, 4, P0);
    addBit(1, 1, 0, 1, 5, P0); addBit(1, 1, 1, 2, 6, P0);
    addVec(0, 6'b0, 0, 0, 1, 0, 0, 2, 6, P0);
    // 101010 with overlap: matches on bits 6 and 8
    addVec(1, P1, 0, 0, 1, 0, 0, 2, 0, P1);
    addBit(1, 1, 0, 2, 1, P1); addBit(0, 1, 0, 2, 2, P1);
    addBit(1, 1, 0, 2, 3, P1); addBit(0, 1, 0, 2, 4, P1);
    addBit(1, 1, 0, 2, 5, P1); addBit(0, 1, 1, 3, 6, P1);
    addBit(1, 1, 0, 3, 6, P1); addBit(0, 1, 1, 4, 6, P1);
    // 101010 without overlap: single match
    addVec(1, P1, 0, 0, 0, 0, 0, 4, 0, P1);
    addBit(1, 0, 0, 4, 1, P1); addBit(0, 0, 0, 4, 2, P1);
    addBit(1, 0, 0, 4, 3, P1); addBit(0, 0, 0, 4, 4, P1);
    addBit(1, 0, 0, 4, 5, P1); addBit(0, 0, 1, 5, 0, P1);
    addBit(1, 0, 0, 5, 1, P1); addBit(0, 0, 0, 5, 2, P1);
    // Back to 101011, valid bits interleaved with idle zero bits
    addVec(1, P0, 0, 0, 0, 0, 0, 5, 0, P0);
    addBit(1, 0, 0, 5, 1, P0); addVec(0, 6'b0, 0, 0, 0, 0, 0, 5, 1, P0);
    addBit(0, 0, 0, 5, 2, P0); addVec(0, 6'b0, 0, 0, 0, 0, 0, 5, 2, P0);
    addBit(1, 0, 0, 5, 3, P0); addVec(0, 6'b0, 0, 0, 0, 0, 0, 5, 3, P0);
    addBit(0, 0, 0, 5, 4, P0); addVec(0, 6'b0, 0, 0, 0, 0, 0, 5, 4, P0);
    addBit(1, 0, 0, 5, 5, P0); addVec(0, 6'b0, 0, 0, 0, 0, 0, 5, 5, P0);
    addBit(1, 0, 1, 6, 0, P0); addVec(0, 6'b0, 0, 0, 0, 0, 0, 6, 0, P0);
    // Counter clear on the completing edge wins over the increment
    addBit(1, 0, 0, 6, 1, P0); addBit(0, 0, 0, 6, 2, P0);
    addBit(1, 0, 0, 6, 3, P0); addBit(0, 0, 0, 6, 4, P0);
    addBit(1, 0, 0, 6, 5, P0);
    addVec(0, 6'b0, 1, 1, 0, 1, 1, 0, 0, P0);
    addVec(0, 6'b0, 0, 0, 0, 0, 0, 0, 0, P0);
    // Load on the completing edge suppresses the match
    addBit(1, 0, 0, 0, 1, P0); addBit(0, 0, 0, 0, 2, P0);
    addBit(1, 0, 0, 0, 3, P0); addBit(0, 0, 0, 0, 4, P0);
    addBit(1, 0, 0, 0, 5, P0);
    addVec(1, P2, 1, 1, 0, 0, 0, 0, 0, P2);
    addVec(1, P0, 0, 0, 0, 0, 0, 0, 0, P0);

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset flag", int'(bus.flag), 0);
    checkOutput("reset cnt", int'(bus.match_cnt), 0);
    checkOutput("reset fill", int'(bus.fill), 0);
    checkOutput("reset pat", int'(bus.pat), int'(P0));
    @(posedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkVec(i, vecs[i]);
    end

    // Asynchronous reset between edges discards a partial sequence
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      applyStimulus(v);
    end
    checkOutput("pre-reset cnt", int'(bus.match_cnt), 1);
    addVec(1, P2, 0, 0, 0, 0, 0, 1, 0, P2);
    applyStimulus(vecs[vecs.size()-1]);
    checkOutput("pre-reset pat", int'(bus.pat), int'(P2));
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      applyStimulus(v);
    end
    checkOutput("pre-reset fill", int'(bus.fill), 5);
    #1 reset = 1'b0;
    #1;
    checkOutput("async reset fill", int'(bus.fill), 0);
    checkOutput("async reset pat", int'(bus.pat), int'(P0));
    #1 reset = 1'b1;
    addVec(0, 6'b0, 1, 1, 0, 0, 0, 0, 1, P0);
    applyStimulus(vecs[vecs.size()-1]);
    checkVec(900, vecs[vecs.size()-1]);

    // Two-bit counter saturates with an all-ones pattern in overlap mode
    @(posedge clk);
    bus2.load = 1; bus2.load_pat = 6'b111111; bus2.overlap = 1;
    @(negedge clk);
    #1;
    checkOutput("sat load pat", int'(bus2.pat), 63);
    flags2 = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      bus2.load = 0; bus2.in_valid = 1; bus2.in_bit = 1;
      @(negedge clk);
      #1;
      if (bus2.flag) flags2++;
      exp_cnt2 = (i >= 6) ? ((i - 5 > 3) ? 3 : i - 5) : 0;
      checkOutput($sformatf("sat bit%0d flag", i), int'(bus2.flag),
                  (i >= 6) ? 1 : 0);
      checkOutput($sformatf("sat bit%0d cnt", i), int'(bus2.match_cnt), exp_cnt2);
    end
    checkOutput("sat flag total", flags2, 5);
    @(posedge clk);
    bus2.in_valid = 0;
    @(negedge clk);
    #1;
    checkOutput("sat idle flag", int'(bus2.flag), 0);
    checkOutput("sat idle fill", int'(bus2.fill), 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
